// File: rtl/sfi_pkg.sv
// Shared SFI constants, opcode classifier and output-slot state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sfi_pkg;

    localparam logic [63:0] ADDR_KEEP_MASK = 64'h00FF_FFFF_FFFF_FFFF;
    localparam logic [7:0]  DEFAULT_TAG    = 8'hA2;

    localparam logic [5:0] OP_SB  = 6'd40;
    localparam logic [5:0] OP_SH  = 6'd41;
    localparam logic [5:0] OP_SWL = 6'd42;
    localparam logic [5:0] OP_SW  = 6'd43;
    localparam logic [5:0] OP_SDL = 6'd44;
    localparam logic [5:0] OP_SDR = 6'd45;
    localparam logic [5:0] OP_SWR = 6'd46;
    localparam logic [5:0] OP_SC  = 6'd56;
    localparam logic [5:0] OP_SCD = 6'd60;
    localparam logic [5:0] OP_SD  = 6'd63;

    typedef enum logic {EMPTY, FULL} state_t;

    function automatic logic is_sfi_op(input logic [5:0] opcode);
        return opcode inside {OP_SB, OP_SH, OP_SWL, OP_SW, OP_SDL,
                              OP_SDR, OP_SWR, OP_SC, OP_SCD, OP_SD};
    endfunction

endpackage

// File: rtl/sfi_rewrite_core.sv
// Forces the sandbox tag into the top byte of memory-access instruction words.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module sfi_rewrite_core
    import sfi_pkg::*;
(
    input  logic [63:0] word,
    input  logic [7:0]  tag,
    output logic [63:0] out_word,
    output logic        hit
);

    always_comb begin
        hit      = is_sfi_op(word[31:26]);
        out_word = hit ? ({tag, 56'd0} | (word & ADDR_KEEP_MASK)) : word;
    end

endmodule

// File: rtl/sfi_rewrite_arbiter.sv
// Round-robin arbiter feeding one registered SFI rewrite stage.
// Latency: one cycle from grant to out_valid.
// Backpressure: grants only while the output slot is empty or being drained.
module sfi_rewrite_arbiter #(
    parameter int         NUM_REQ     = 4,
    parameter int         CNT_W       = 32,
    parameter logic [7:0] DEFAULT_TAG = 8'hA2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*64-1:0]      req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       out_valid,
    output logic [63:0]                out_data,
    output logic [$clog2(NUM_REQ)-1:0] out_src,
    output logic                       out_rewritten,
    input  logic                       out_ready,
    input  logic                       cfg_we,
    input  logic [7:0]                 cfg_tag,
    output logic [7:0]                 cur_tag,
    output logic [CNT_W-1:0]           rewrite_cnt,
    output logic [CNT_W-1:0]           pass_cnt
);
    import sfi_pkg::*;

    localparam int SRC_W = $clog2(NUM_REQ);

    state_t             state_q, state_d;
    logic [SRC_W-1:0]   rr_ptr, grant_idx, hi_idx, lo_idx;
    logic               accept, grant, hi_vld, lo_vld, deliver, rw_hit;
    logic [63:0]        grant_word, rw_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (grant) state_d = FULL;
            FULL:    if (out_ready && !grant) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state_q == FULL);
        accept    = (state_q == EMPTY) | out_ready;
        deliver   = out_valid & out_ready;
        req_ready = '0;
        if (grant) req_ready[grant_idx] = 1'b1;
    end

    // Search split in two: requesters at or above the pointer first, then any (wrap-around).
    always_comb begin
        hi_vld = 1'b0;
        lo_vld = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_vld = 1'b1;
                lo_idx = SRC_W'(i);
                if (SRC_W'(i) >= rr_ptr) begin
                    hi_vld = 1'b1;
                    hi_idx = SRC_W'(i);
                end
            end
        end
        // Gated by rst_n so no requester sees an accept while the block is held in reset.
        grant     = rst_n & accept & lo_vld;
        grant_idx = hi_vld ? hi_idx : lo_idx;
        grant_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (SRC_W'(i) == grant_idx) grant_word = req_data[64*i +: 64];
        end
    end

    sfi_rewrite_core u_core (
        .word     (grant_word),
        .tag      (cur_tag),
        .out_word (rw_word),
        .hit      (rw_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data      <= '0;
            out_src       <= '0;
            out_rewritten <= 1'b0;
            rr_ptr        <= '0;
            cur_tag       <= DEFAULT_TAG;
            rewrite_cnt   <= '0;
            pass_cnt      <= '0;
        end else begin
            if (grant) begin
                out_data      <= rw_word;
                out_src       <= grant_idx;
                out_rewritten <= rw_hit;
                rr_ptr        <= (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (cfg_we) cur_tag <= cfg_tag;
            if (deliver && out_rewritten && !(&rewrite_cnt)) rewrite_cnt <= rewrite_cnt + 1'b1;
            if (deliver && !out_rewritten && !(&pass_cnt))   pass_cnt    <= pass_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_sfi_rewrite_arbiter.sv
// Directed plus randomized bench for sfi_rewrite_arbiter against a cycle-level reference model.
module tb_sfi_rewrite_arbiter;

    localparam int N  = 4;
    localparam int CW = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N*64-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              out_valid;
    logic [63:0]       out_data;
    logic [1:0]        out_src;
    logic              out_rewritten;
    logic              out_ready;
    logic              cfg_we;
    logic [7:0]        cfg_tag;
    logic [7:0]        cur_tag;
    logic [CW-1:0]     rewrite_cnt;
    logic [CW-1:0]     pass_cnt;

    int total = 0;
    int bad   = 0;

    bit          m_valid;
    logic [63:0] m_data;
    int          m_src;
    bit          m_rw;
    int          m_ptr;
    logic [7:0]  m_tag;
    longint      m_rcnt, m_pcnt;
    longint      cnt_max = (64'd1 << CW) - 1;
    logic [5:0]  ops [10] = '{6'd40, 6'd41, 6'd42, 6'd43, 6'd44, 6'd45, 6'd46, 6'd56, 6'd60, 6'd63};
    int          rr_start;

    sfi_rewrite_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_src       (out_src),
        .out_rewritten (out_rewritten),
        .out_ready     (out_ready),
        .cfg_we        (cfg_we),
        .cfg_tag       (cfg_tag),
        .cur_tag       (cur_tag),
        .rewrite_cnt   (rewrite_cnt),
        .pass_cnt      (pass_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit sfi_op(input logic [63:0] w);
        logic [5:0] op;
        op = w[31:26];
        foreach (ops[k]) if (ops[k] == op) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_data = '0; m_src = 0; m_rw = 0;
        m_ptr = 0; m_tag = 8'hA2; m_rcnt = 0; m_pcnt = 0;
    endtask

    // One clock cycle: check the combinational grant, advance the model, check registered outputs.
    task automatic step();
        int g, idx;
        logic [N-1:0] er;
        logic [63:0] w;
        bit acc;
        #3;
        acc = !m_valid || out_ready;
        g = -1;
        if (acc) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", req_ready, er);
        @(posedge clk);
        if (m_valid && out_ready) begin
            if (m_rw) m_rcnt = (m_rcnt == cnt_max) ? m_rcnt : m_rcnt + 1;
            else      m_pcnt = (m_pcnt == cnt_max) ? m_pcnt : m_pcnt + 1;
        end
        if (g >= 0) begin
            w       = req_data[g*64 +: 64];
            m_rw    = sfi_op(w);
            m_data  = m_rw ? {m_tag, w[55:0]} : w;
            m_src   = g;
            m_valid = 1;
            m_ptr   = (g + 1) % N;
        end else if (out_ready) begin
            m_valid = 0;
        end
        if (cfg_we) m_tag = cfg_tag;
        #1;
        chk("out_valid", out_valid, m_valid);
        chk("out_data", out_data, m_data);
        chk("out_src", out_src, m_src);
        chk("out_rewritten", out_rewritten, m_rw);
        chk("cur_tag", cur_tag, m_tag);
        chk("rewrite_cnt", rewrite_cnt, m_rcnt);
        chk("pass_cnt", pass_cnt, m_pcnt);
        if (g >= 0) req_valid[g] = 1'b0;
    endtask

    task automatic post(input int i, input logic [63:0] w);
        req_valid[i] = 1'b1;
        req_data[i*64 +: 64] = w;
    endtask

    initial begin
        rst_n = 0; req_valid = '0; req_data = '0;
        out_ready = 0; cfg_we = 0; cfg_tag = '0;
        model_reset();
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_req_ready", req_ready, 4'd0);
        chk("rst_cur_tag", cur_tag, 8'hA2);
        chk("rst_rewrite_cnt", rewrite_cnt, 32'd0);
        chk("rst_pass_cnt", pass_cnt, 32'd0);
        @(posedge clk);
        #1 rst_n = 1;

        // Rewrite and pass-through
        out_ready = 1;
        post(0, 64'h12345678_A0000010);
        step();
        chk("rw_data", out_data, 64'hA2345678_A0000010);
        chk("rw_flag", out_rewritten, 1'b1);
        chk("rw_src", out_src, 2'd0);
        post(1, 64'hFFFF0000_BC000001);
        step();
        chk("rw_cnt1", rewrite_cnt, 32'd1);
        chk("pass_data", out_data, 64'hFFFF0000_BC000001);
        chk("pass_flag", out_rewritten, 1'b0);
        post(1, 64'h00000000_FC000000);
        step();
        chk("pass_cnt1", pass_cnt, 32'd1);
        chk("op63_data", out_data, 64'hA2000000_FC000000);
        step();
        chk("drain_valid", out_valid, 1'b0);

        // Tag write coinciding with a grant uses the old tag
        post(2, 64'hAB000000_E0000000);
        cfg_we = 1; cfg_tag = 8'h5C;
        step();
        cfg_we = 0;
        chk("cfg_old_tag", out_data, 64'hA2000000_E0000000);
        post(2, 64'hAB000000_E0000000);
        step();
        chk("cfg_new_tag", out_data, 64'h5C000000_E0000000);

        // Round-robin with every requester always valid
        rr_start = m_ptr;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++)
                if (!req_valid[i]) post(i, {$urandom, $urandom});
            step();
            chk("rr_src", out_src, (rr_start + k) % N);
            chk("rr_valid", out_valid, 1'b1);
        end

        // Backpressure holds the slot and withholds grants
        out_ready = 0;
        for (int k = 0; k < 5; k++) step();
        out_ready = 1;
        step();

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && ($urandom % 2) == 0) begin
                    post(i, {$urandom, $urandom});
                    if ($urandom % 2) req_data[i*64 + 26 +: 6] = ops[$urandom % 10];
                end
            end
            out_ready = ($urandom % 4) != 0;
            cfg_we    = ($urandom % 20) == 0;
            cfg_tag   = 8'($urandom);
            step();
        end
        cfg_we = 0;

        // Asynchronous reset while the slot is full
        out_ready = 0;
        post(0, 64'h12345678_A0000010);
        step();
        #2 rst_n = 0;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_rewrite_cnt", rewrite_cnt, 32'd0);
        chk("arst_pass_cnt", pass_cnt, 32'd0);
        chk("arst_cur_tag", cur_tag, 8'hA2);
        chk("arst_req_ready", req_ready, 4'd0);
        model_reset();
        req_valid = '0;
        @(posedge clk);
        #1 rst_n = 1;
        out_ready = 1;
        post(3, 64'h00000000_00000001);
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
